// File: rtl/tx_byte_serializer.sv
// tx_byte_serializer
//   Selects one of NUM_SRC parallel words, parks it in a one-entry holding
//   register under a ready/valid handshake and shifts it out one bit per
//   shift_enable strobe. A word waiting in the holding register is loaded
//   on the final strobe of the current word, so consecutive words leave
//   with no idle bit between them.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   src_data     NUM_SRC flattened words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_sel      source index, sampled on the accept edge
//   load_valid   producer offers the selected word
//   load_ready   holding register empty
//   shift_enable bit strobe
//   flush        synchronous abort, highest priority
//   out_bit      serial output (IDLE_BIT when not shifting)
//   byte_done    one-cycle pulse after the last bit of a word
//   busy         shifting or holding register full
module tx_byte_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = 4,
   parameter bit SHIFT_MSB  = 1'b0,
   parameter bit IDLE_BIT   = 1'b1,
   localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [SEL_W-1:0]              src_sel,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic                          shift_enable,
   input  logic                          flush,
   output logic                          out_bit,
   output logic                          byte_done,
   output logic                          busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t                              state_q, state_d;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_arr;
   logic [DATA_WIDTH-1:0]               sel_word;
   logic [DATA_WIDTH-1:0]               hold_q;
   logic                                hold_full;
   logic [DATA_WIDTH-1:0]               sreg;
   logic [CNT_W-1:0]                    cnt;
   logic                                accept;
   logic                                shift_step;
   logic                                last_bit;
   logic                                load_sreg;

   assign src_arr = src_data;

   // Compare-based mux: an index with no matching source (including
   // non-power-of-two NUM_SRC) yields an all-zero word.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (src_sel == SEL_W'(i)) sel_word = src_arr[i];
   end

   // Accept only into an empty hold; a transfer needs a full hold, so the
   // two can never happen on the same edge.
   assign accept     = load_valid && !hold_full && !flush;
   assign shift_step = (state_q == S_SHIFT) && shift_enable;
   assign last_bit   = shift_step && (cnt == LAST);
   assign load_sreg  = hold_full && ((state_q == S_IDLE) || last_bit);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (hold_full)             state_d = S_SHIFT;
            S_SHIFT: if (last_bit && !hold_full) state_d = S_IDLE;
            default:                            state_d = S_IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      out_bit = IDLE_BIT;
      if (state_q == S_SHIFT)
         out_bit = SHIFT_MSB ? sreg[DATA_WIDTH-1] : sreg[0];
      busy       = (state_q == S_SHIFT) || hold_full;
      load_ready = !hold_full;
   end

   // Datapath: holding register, shift register, bit counter, done pulse
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hold_q    <= '0;
         hold_full <= 1'b0;
         sreg      <= '0;
         cnt       <= '0;
         byte_done <= 1'b0;
      end else if (flush) begin
         hold_full <= 1'b0;
         cnt       <= '0;
         byte_done <= 1'b0;
      end else begin
         byte_done <= last_bit;
         if (accept) begin
            hold_q    <= sel_word;
            hold_full <= 1'b1;
         end else if (load_sreg) begin
            hold_full <= 1'b0;
         end
         if (load_sreg) begin
            sreg <= hold_q;
            cnt  <= '0;
         end else if (last_bit) begin
            cnt  <= '0;
         end else if (shift_step) begin
            sreg <= SHIFT_MSB ? (sreg << 1) : (sreg >> 1);
            cnt  <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/tx_byte_serializer.md
# tx_byte_serializer

Parametrised parallel-to-serial byte engine for the transmitter datapath. It selects one of NUM_SRC parallel sources, latches the byte into a one-entry holding register under a ready/valid handshake, and serialises it on a bit-rate strobe. Back-to-back bytes go out with no idle bit between them. It sits between the transmit FSM/FIFO/CRC byte sources and the line encoder, and reports byte completion so the FSM can sequence packets.

## Interface
- DATA_WIDTH, 8: bits per word.
- NUM_SRC, 4: number of parallel sources; the select width is SEL_W = max(1, clog2(NUM_SRC)), a derived localparam.
- SHIFT_MSB, 0: 0 = LSB first, 1 = MSB first.
- IDLE_BIT, 1: out_bit level whenever no word is being shifted.
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- src_data  in  NUM_SRC*DATA_WIDTH  flattened sources; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_sel  in  SEL_W  source index, sampled on the accept edge.
- load_valid  in  1  producer offers the selected word.
- load_ready  out  1  holding register is empty; equals !hold_full.
- shift_enable  in  1  bit strobe; one strobe sends one bit.
- flush  in  1  synchronous abort; has priority over all other inputs.
- out_bit  out  1  serial output.
- byte_done  out  1  one-cycle pulse after the last bit of a word is shifted.
- busy  out  1  high while shifting or while the holding register is full.

## Operation
- Accept: on a rising edge with load_valid && load_ready, hold <= the selected slice and hold_full <= 1.
  - If src_sel >= NUM_SRC, hold <= 0.
- Shifter state machine:
  - IDLE: out_bit = IDLE_BIT. If hold_full, the next edge transfers hold into the shift register, clears hold_full, sets cnt <= 0 and moves to SHIFT. shift_enable is ignored in IDLE.
  - SHIFT: out_bit = sreg[0] when SHIFT_MSB = 0, or sreg[DATA_WIDTH-1] when SHIFT_MSB = 1. On an edge with shift_enable:
    - cnt < DATA_WIDTH-1: shift toward the output end and increment cnt.
    - cnt == DATA_WIDTH-1: assert byte_done next cycle. If hold_full, reload from hold, clear hold_full, set cnt <= 0 and stay in SHIFT (seamless). Otherwise go to IDLE.
- cnt width is clog2(DATA_WIDTH); it never exceeds DATA_WIDTH-1.
- load_ready is registered-derived. A word can be accepted on the same edge the holding register empties only if hold_full was already 0 before that edge. Hold transfer and a new accept therefore never collide.
- busy = (state == SHIFT) || hold_full.
- flush: on the edge it is seen, state <= IDLE, hold_full <= 0, cnt <= 0, byte_done <= 0. Any concurrent load_valid is ignored. out_bit returns to IDLE_BIT after that edge.
- Reset (n_rst low, asynchronous): state IDLE, hold_full 0, sreg 0, cnt 0, byte_done 0.
  - Resulting outputs: out_bit = IDLE_BIT, load_ready = 1, busy = 0.
  - Reset mid-word discards all data with no byte_done.

## Timing
- Accept at edge E0 (from IDLE, empty): load_ready is 0 after E0. At E1 the word moves to the shifter, and bit 0 appears on out_bit after E1. load_ready returns to 1 after E1.
- A strobe coincident with E1 does not shift. Each later strobed edge advances out_bit by one bit.
- A word occupies out_bit for exactly DATA_WIDTH strobes.
- byte_done is high for exactly one clk cycle after the edge carrying the final strobe.
- With hold_full at the final strobe, the next word's first bit appears after that same edge: zero idle bits between words.
- Sustained throughput is one word per DATA_WIDTH strobes, provided the producer refills within DATA_WIDTH-1 strobes after load_ready rises.
- shift_enable held high continuously is legal: one bit per clock.

## Test plan
- Reset: assert n_rst low mid-word -> out_bit = 1, load_ready = 1, busy = 0, byte_done = 0 immediately. No byte_done after release.
- Single word, DATA_WIDTH = 8, SHIFT_MSB = 0, src_sel = 2, src_data slice 2 = 8'hA5, strobe every 4 clocks:
  - out_bit = 1,0,1,0,0,1,0,1.
  - byte_done pulses once after the 8th strobe.
  - out_bit then returns to 1, and busy falls the same cycle.
- Back-to-back: 8'h80 then 8'h01 (SHIFT_MSB = 0), second word accepted during the first:
  - 16 contiguous bits 0000000110000000 with no IDLE_BIT gap.
  - Two byte_done pulses 8 strobes apart.
- Handshake: hold load_valid high continuously with a new value every accepted cycle -> load_ready is low whenever hold is full. No word is lost or duplicated across 4 words (FSM 8'h2D, FIFO 8'h3C, CRC 8'hF0, CRC 8'h0F via src_sel 1,0,2,3).
- Out-of-range select with NUM_SRC = 3, src_sel = 3 -> eight zero bits are shifted and byte_done pulses.
- flush asserted after the 3rd strobe with hold full and load_valid high -> next cycle out_bit = 1, busy = 0, load_ready = 1, no byte_done. A subsequent accept of 8'hFF shifts eight 1s normally.
